// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and RAM signal bundle around the shared memory port arbiter
interface mem_port_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_flush_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  modport slave (
    input  if_req_i, if_addr_i, if_flush_i, d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
  modport master (
    output if_req_i, if_addr_i, if_flush_i, d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between fetch and data, routing read responses to their owner
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst_i,
  mem_port_arbiter_if.slave  bus
);
  logic [3:0]             r_starve;
  logic [MEM_LATENCY-1:0] r_vld;
  logic [MEM_LATENCY-1:0] r_own;
  logic [MEM_LATENCY-1:0] w_keep;
  logic                   w_force_if;
  logic                   w_d_gnt;
  logic                   w_if_gnt;
  logic                   w_push;
  assign w_force_if = bus.if_req_i && r_starve == 4'(STARVE_LIMIT);
  assign w_d_gnt    = !rst_i && bus.d_req_i && !w_force_if;
  assign w_if_gnt   = !rst_i && bus.if_req_i && !w_d_gnt;
  // a fetch granted while flushing is never tracked, so its response cannot surface
  assign w_push     = (w_if_gnt && !bus.if_flush_i) || (w_d_gnt && !bus.d_we_i);
  assign w_keep     = r_vld & ~({MEM_LATENCY{bus.if_flush_i}} & ~r_own);
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_starve <= '0;
      r_vld    <= '0;
      r_own    <= '0;
    end else begin
      r_starve <= (!bus.if_req_i || w_if_gnt) ? 4'd0 :
                  (r_starve == 4'(STARVE_LIMIT)) ? r_starve : r_starve + 4'd1;
      r_vld    <= MEM_LATENCY'({w_keep, w_push});
      r_own    <= MEM_LATENCY'({r_own, w_d_gnt});
    end
  end
  always_comb begin
    bus.if_gnt_o    = w_if_gnt;
    bus.d_gnt_o     = w_d_gnt;
    bus.mem_en_o    = w_if_gnt || w_d_gnt;
    bus.mem_we_o    = w_d_gnt && bus.d_we_i;
    bus.mem_be_o    = w_d_gnt ? bus.d_be_i : w_if_gnt ? 4'hF : 4'h0;
    bus.mem_addr_o  = w_d_gnt ? bus.d_addr_i : w_if_gnt ? bus.if_addr_i : 32'h0;
    bus.mem_wdata_o = w_d_gnt ? bus.d_wdata_i : 32'h0;
    bus.if_rvalid_o = !rst_i && w_keep[MEM_LATENCY-1] && !r_own[MEM_LATENCY-1];
    bus.d_rvalid_o  = !rst_i && w_keep[MEM_LATENCY-1] && r_own[MEM_LATENCY-1];
    bus.if_rdata_o  = bus.mem_rdata_i;
    bus.d_rdata_o   = bus.mem_rdata_i;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant, starvation, routing and flush at latencies 1, 2 and 3
module tb_mem_port_arbiter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [31:0] ram1 [256];
  logic [31:0] rd1;
  logic [31:0] p2 [2];
  logic [31:0] p3 [3];
  mem_port_arbiter_if b1 ();
  mem_port_arbiter_if b2 ();
  mem_port_arbiter_if b3 ();
  mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u1 (.clk(clk), .rst_i(rst), .bus(b1));
  mem_port_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(4)) u2 (.clk(clk), .rst_i(rst), .bus(b2));
  mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) u3 (.clk(clk), .rst_i(rst), .bus(b3));
  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1357_0000 | a;
  endfunction
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always_ff @(posedge clk) begin
    if (b1.mem_en_o) begin
      if (b1.mem_we_o) begin
        for (int k = 0; k < 4; k++)
          if (b1.mem_be_o[k]) ram1[b1.mem_addr_o[9:2]][8*k +: 8] <= b1.mem_wdata_o[8*k +: 8];
      end else rd1 <= ram1[b1.mem_addr_o[9:2]];
    end
    p2[0] <= rom(b2.mem_addr_o);
    p2[1] <= p2[0];
    p3[0] <= rom(b3.mem_addr_o);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign b1.mem_rdata_i = rd1;
  assign b2.mem_rdata_i = p2[1];
  assign b3.mem_rdata_i = p3[2];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic nx();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [5:0] pat;
    logic [8:0] ifp;
    logic [8:0] dxp;
    n_cmp = 0;
    n_bad = 0;
    rd1 = '0;
    for (int i = 0; i < 256; i++) ram1[i] = rom(32'(i) << 2);
    rst = 1'b1;
    {b1.if_req_i, b1.if_flush_i, b1.d_req_i, b1.d_we_i} = '0;
    {b2.if_req_i, b2.if_flush_i, b2.d_req_i, b2.d_we_i} = '0;
    {b3.if_req_i, b3.if_flush_i, b3.d_req_i, b3.d_we_i} = '0;
    {b1.if_addr_i, b1.d_addr_i, b1.d_wdata_i, b1.d_be_i} = '0;
    {b2.if_addr_i, b2.d_addr_i, b2.d_wdata_i, b2.d_be_i} = '0;
    {b3.if_addr_i, b3.d_addr_i, b3.d_wdata_i, b3.d_be_i} = '0;
    nx();
    b1.if_req_i = 1'b1;
    b1.d_req_i  = 1'b1;
    #4;
    chk("rst_if_gnt", b1.if_gnt_o, 0);
    chk("rst_d_gnt", b1.d_gnt_o, 0);
    chk("rst_mem_en", b1.mem_en_o, 0);
    nx();
    chk("rst_d_rvalid", b1.d_rvalid_o, 0);
    rst = 1'b0;
    #4;
    chk("rel_d_gnt", b1.d_gnt_o, 1);
    chk("rel_if_gnt", b1.if_gnt_o, 0);
    nx();
    b1.if_req_i = 1'b0;
    b1.d_req_i  = 1'b0;
    nx();
    for (int i = 0; i < 4; i++) begin
      b1.if_req_i  = (i < 3);
      b1.if_addr_i = 32'(i) * 4;
      #4;
      if (i < 3) chk("fetch_gnt", b1.if_gnt_o, 1);
      if (i < 3) chk("fetch_be", b1.mem_be_o, 4'hF);
      if (i > 0) chk("fetch_rvalid", b1.if_rvalid_o, 1);
      if (i > 0) chk("fetch_rdata", b1.if_rdata_o, rom(32'(i - 1) * 4));
      chk("fetch_no_d_rvalid", b1.d_rvalid_o, 0);
      nx();
    end
    pat = 6'b101111;
    b1.if_req_i  = 1'b1;
    b1.if_addr_i = 32'h40;
    b1.d_req_i   = 1'b1;
    b1.d_addr_i  = 32'h80;
    for (int i = 0; i < 6; i++) begin
      #4;
      chk("cont_d_gnt", b1.d_gnt_o, pat[i]);
      chk("cont_if_gnt", b1.if_gnt_o, !pat[i]);
      chk("cont_addr", b1.mem_addr_o, pat[i] ? 32'h80 : 32'h40);
      nx();
    end
    b1.if_req_i = 1'b0;
    b1.d_req_i  = 1'b0;
    nx();
    b1.d_req_i   = 1'b1;
    b1.d_we_i    = 1'b1;
    b1.d_be_i    = 4'hF;
    b1.d_addr_i  = 32'h100;
    b1.d_wdata_i = 32'hDEADBEEF;
    #4;
    chk("st_gnt", b1.d_gnt_o, 1);
    chk("st_mem_we", b1.mem_we_o, 1);
    chk("st_wdata", b1.mem_wdata_o, 32'hDEADBEEF);
    nx();
    b1.d_be_i    = 4'b0011;
    b1.d_addr_i  = 32'h104;
    b1.d_wdata_i = 32'hAAAA5555;
    #4;
    chk("st_no_rvalid", b1.d_rvalid_o, 0);
    chk("st_be", b1.mem_be_o, 4'b0011);
    nx();
    b1.d_we_i   = 1'b0;
    b1.d_addr_i = 32'h100;
    #4;
    chk("st2_no_rvalid", b1.d_rvalid_o, 0);
    chk("ld_mem_we", b1.mem_we_o, 0);
    nx();
    b1.d_addr_i = 32'h104;
    #4;
    chk("ld_rvalid", b1.d_rvalid_o, 1);
    chk("ld_rdata", b1.d_rdata_o, 32'hDEADBEEF);
    chk("ld_no_if_rvalid", b1.if_rvalid_o, 0);
    nx();
    b1.d_req_i = 1'b0;
    #4;
    chk("ld_be_rvalid", b1.d_rvalid_o, 1);
    chk("ld_be_rdata", b1.d_rdata_o, 32'h13575555);
    nx();
    #4;
    chk("idle_d_rvalid", b1.d_rvalid_o, 0);
    chk("idle_mem_en", b1.mem_en_o, 0);
    nx();
    ifp = 9'b111110111;
    dxp = 9'b011111111;
    b1.d_req_i  = 1'b1;
    b1.d_addr_i = 32'h80;
    for (int i = 0; i < 9; i++) begin
      b1.if_req_i = ifp[i];
      #4;
      chk("clr_d_gnt", b1.d_gnt_o, dxp[i]);
      chk("clr_if_gnt", b1.if_gnt_o, !dxp[i]);
      nx();
    end
    b1.if_req_i = 1'b0;
    b1.d_req_i  = 1'b0;
    b2.if_req_i  = 1'b1;
    b2.if_addr_i = 32'h20;
    #4;
    chk("fl_if_gnt", b2.if_gnt_o, 1);
    nx();
    b2.if_req_i   = 1'b0;
    b2.if_flush_i = 1'b1;
    b2.d_req_i    = 1'b1;
    b2.d_addr_i   = 32'h30;
    #4;
    chk("fl_d_gnt", b2.d_gnt_o, 1);
    nx();
    b2.if_flush_i = 1'b0;
    b2.d_req_i    = 1'b0;
    #4;
    chk("fl_killed", b2.if_rvalid_o, 0);
    chk("fl_no_d_early", b2.d_rvalid_o, 0);
    nx();
    b2.if_req_i   = 1'b1;
    b2.if_addr_i  = 32'h24;
    b2.if_flush_i = 1'b1;
    #4;
    chk("fl_d_rvalid", b2.d_rvalid_o, 1);
    chk("fl_d_rdata", b2.d_rdata_o, rom(32'h30));
    chk("fl_same_gnt", b2.if_gnt_o, 1);
    nx();
    b2.if_flush_i = 1'b0;
    b2.if_addr_i  = 32'h28;
    nx();
    b2.if_req_i = 1'b0;
    #4;
    chk("fl_same_killed", b2.if_rvalid_o, 0);
    nx();
    #4;
    chk("fl_after_rvalid", b2.if_rvalid_o, 1);
    chk("fl_after_rdata", b2.if_rdata_o, rom(32'h28));
    nx();
    for (int i = 0; i < 8; i++) begin
      b3.if_req_i  = (i < 4) && (i % 2 == 0);
      b3.d_req_i   = (i < 4) && (i % 2 == 1);
      b3.if_addr_i = 32'h200 + 32'(i) * 4;
      b3.d_addr_i  = 32'h300 + 32'(i) * 4;
      #4;
      chk("mix_if_rvalid", b3.if_rvalid_o, (i == 3 || i == 5));
      chk("mix_d_rvalid", b3.d_rvalid_o, (i == 4 || i == 6));
      if (i == 3 || i == 5) chk("mix_if_rdata", b3.if_rdata_o, rom(32'h200 + 32'(i - 3) * 4));
      if (i == 4 || i == 6) chk("mix_d_rdata", b3.d_rdata_o, rom(32'h300 + 32'(i - 3) * 4));
      nx();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
